// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, state encoding, op classes.
package cpu_ctrl_pkg;

   localparam int unsigned AluOpW = 5;

   typedef logic [AluOpW-1:0] opcode_t;

   localparam opcode_t OpAdd  = 5'b00011;
   localparam opcode_t OpSub  = 5'b00100;
   localparam opcode_t OpAnd  = 5'b00101;
   localparam opcode_t OpOr   = 5'b00110;
   localparam opcode_t OpAddi = 5'b01100;
   localparam opcode_t OpAndi = 5'b01101;
   localparam opcode_t OpOri  = 5'b01110;
   localparam opcode_t OpJr   = 5'b10100;
   localparam opcode_t OpNop  = 5'b11010;
   localparam opcode_t OpHalt = 5'b11011;

   typedef enum logic [2:0] {
      StT0   = 3'd0,
      StT1   = 3'd1,
      StT2   = 3'd2,
      StT3   = 3'd3,
      StT4   = 3'd4,
      StT5   = 3'd5,
      StHalt = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      ClsRegAlu = 3'd0,
      ClsImm    = 3'd1,
      ClsJr     = 3'd2,
      ClsHalt   = 3'd3,
      ClsOther  = 3'd4
   } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classification of the instruction opcode.
module opcode_class_decode
   import cpu_ctrl_pkg::*;
(
   input  opcode_t   opcode,
   output op_class_t op_class
);

   // Map each opcode to the execute sequence it needs; unknown opcodes run as nop.
   always_comb begin
      op_class = ClsOther;
      case (opcode)
         OpAdd, OpSub, OpAnd, OpOr: op_class = ClsRegAlu;
         OpAddi, OpAndi, OpOri:     op_class = ClsImm;
         OpJr:                      op_class = ClsJr;
         OpHalt:                    op_class = ClsHalt;
         default:                   op_class = ClsOther;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer: fetch (T0-T2), execute (T3-T5), HALT.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ir,
   input  logic              mem_ready,
   input  logic              stop,
   output logic              PCout,
   output logic              MARin,
   output logic              IncPC,
   output logic              Zin,
   output logic              Zlowout,
   output logic              PCin,
   output logic              Read,
   output logic              MDRin,
   output logic              MDRout,
   output logic              IRin,
   output logic              Yin,
   output logic              Cout,
   output logic              Gra,
   output logic              Grb,
   output logic              Grc,
   output logic              Rin,
   output logic              Rout,
   output logic              BAout,
   output logic [AluOpW-1:0] alu_op,
   output logic              run
);

   state_t    state, state_next;
   logic      first_t1;
   opcode_t   opcode;
   op_class_t op_class;

   assign opcode = ir[31:27];

   opcode_class_decode u_decode (
      .opcode   (opcode),
      .op_class (op_class)
   );

   // State register plus flag marking the first cycle of T1 (PC loads once per fetch).
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StT0;
         first_t1 <= 1'b0;
      end else begin
         state    <= state_next;
         first_t1 <= (state == StT0) && !stop;
      end
   end

   // Next-state selection.
   always_comb begin
      state_next = state;
      case (state)
         StT0:    state_next = stop ? StT0 : StT1;
         StT1:    state_next = mem_ready ? StT2 : StT1;
         StT2:    state_next = StT3;
         StT3: begin
            case (op_class)
               ClsRegAlu, ClsImm: state_next = StT4;
               ClsHalt:           state_next = StHalt;
               default:           state_next = StT0;
            endcase
         end
         StT4:    state_next = StT5;
         StT5:    state_next = StT0;
         StHalt:  state_next = StHalt;
         default: state_next = StT0;
      endcase
   end

   // Output decode from current state and opcode; everything is forced low during reset.
   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_op  = '0;
      run     = !reset && (state != StHalt);
      if (!reset) begin
         case (state)
            StT0: begin
               if (!stop) begin
                  PCout = 1'b1;
                  MARin = 1'b1;
                  IncPC = 1'b1;
                  Zin   = 1'b1;
               end
            end
            StT1: begin
               Zlowout = 1'b1;
               PCin    = first_t1;
               Read    = 1'b1;
               MDRin   = 1'b1;
            end
            StT2: begin
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            StT3: begin
               case (op_class)
                  ClsRegAlu, ClsImm: begin
                     Grb  = 1'b1;
                     Rout = 1'b1;
                     Yin  = 1'b1;
                  end
                  ClsJr: begin
                     Gra  = 1'b1;
                     Rout = 1'b1;
                     PCin = 1'b1;
                  end
                  default: ;
               endcase
            end
            StT4: begin
               if (op_class == ClsRegAlu) begin
                  Grc    = 1'b1;
                  Rout   = 1'b1;
                  Zin    = 1'b1;
                  alu_op = opcode;
               end else if (op_class == ClsImm) begin
                  Cout   = 1'b1;
                  Zin    = 1'b1;
                  alu_op = opcode;
               end
            end
            StT5: begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench: per-cycle expected control words go through a scoreboard queue.
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ir;
   logic        mem_ready;
   logic        stop;
   logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, Cout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, run;
   logic [4:0] alu_op;

   control_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .ir        (ir),
      .mem_ready (mem_ready),
      .stop      (stop),
      .PCout     (PCout),
      .MARin     (MARin),
      .IncPC     (IncPC),
      .Zin       (Zin),
      .Zlowout   (Zlowout),
      .PCin      (PCin),
      .Read      (Read),
      .MDRin     (MDRin),
      .MDRout    (MDRout),
      .IRin      (IRin),
      .Yin       (Yin),
      .Cout      (Cout),
      .Gra       (Gra),
      .Grb       (Grb),
      .Grc       (Grc),
      .Rin       (Rin),
      .Rout      (Rout),
      .BAout     (BAout),
      .alu_op    (alu_op),
      .run       (run)
   );

   always #5 clk = ~clk;

   // Control word layout: {18 strobes, alu_op[4:0], run}
   localparam logic [23:0] M_PCOUT = 24'h1 << 23;
   localparam logic [23:0] M_MARIN = 24'h1 << 22;
   localparam logic [23:0] M_INCPC = 24'h1 << 21;
   localparam logic [23:0] M_ZIN   = 24'h1 << 20;
   localparam logic [23:0] M_ZLOW  = 24'h1 << 19;
   localparam logic [23:0] M_PCIN  = 24'h1 << 18;
   localparam logic [23:0] M_READ  = 24'h1 << 17;
   localparam logic [23:0] M_MDRIN = 24'h1 << 16;
   localparam logic [23:0] M_MDROUT= 24'h1 << 15;
   localparam logic [23:0] M_IRIN  = 24'h1 << 14;
   localparam logic [23:0] M_YIN   = 24'h1 << 13;
   localparam logic [23:0] M_COUT  = 24'h1 << 12;
   localparam logic [23:0] M_GRA   = 24'h1 << 11;
   localparam logic [23:0] M_GRB   = 24'h1 << 10;
   localparam logic [23:0] M_GRC   = 24'h1 << 9;
   localparam logic [23:0] M_RIN   = 24'h1 << 8;
   localparam logic [23:0] M_ROUT  = 24'h1 << 7;
   localparam logic [23:0] M_RUN   = 24'h1;

   localparam logic [23:0] E_RST  = 24'h0;
   localparam logic [23:0] E_HALT = 24'h0;
   localparam logic [23:0] E_IDLE = M_RUN;
   localparam logic [23:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
   localparam logic [23:0] E_T1F  = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
   localparam logic [23:0] E_T1S  = M_ZLOW | M_READ | M_MDRIN | M_RUN;
   localparam logic [23:0] E_T2   = M_MDROUT | M_IRIN | M_RUN;
   localparam logic [23:0] E_T3   = M_GRB | M_ROUT | M_YIN | M_RUN;
   localparam logic [23:0] E_T5   = M_ZLOW | M_GRA | M_RIN | M_RUN;
   localparam logic [23:0] E_JR   = M_GRA | M_ROUT | M_PCIN | M_RUN;

   function automatic logic [23:0] e_t4r(input logic [4:0] op);
      return M_GRC | M_ROUT | M_ZIN | M_RUN | ({19'h0, op} << 1);
   endfunction

   function automatic logic [23:0] e_t4i(input logic [4:0] op);
      return M_COUT | M_ZIN | M_RUN | ({19'h0, op} << 1);
   endfunction

   logic [23:0] sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [23:0] observed();
      return {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, Cout,
              Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run};
   endfunction

   // One clock cycle: push expectation with the current inputs, compare at the falling edge.
   task automatic cyc(input string tag, input logic [23:0] e);
      logic [23:0] exp_v;
      logic [23:0] obs_v;
      sb_q.push_back(e);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      n_cmp++;
      assert (obs_v === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] op);
      ir = {op, 27'h5a5a5a5};
   endtask

   initial begin
      reset     = 1'b1;
      stop      = 1'b0;
      mem_ready = 1'b1;
      set_op(OpAdd);
      @(posedge clk);
      #1;
      cyc("reset0", E_RST);
      cyc("reset1", E_RST);
      reset = 1'b0;

      // add, no stalls: six cycles
      cyc("add_t0", E_T0);
      cyc("add_t1", E_T1F);
      cyc("add_t2", E_T2);
      cyc("add_t3", E_T3);
      cyc("add_t4", e_t4r(OpAdd));
      cyc("add_t5", E_T5);

      // addi with three stalled T1 cycles
      set_op(OpAddi);
      cyc("addi_t0", E_T0);
      mem_ready = 1'b0;
      cyc("addi_t1a", E_T1F);
      cyc("addi_t1b", E_T1S);
      cyc("addi_t1c", E_T1S);
      mem_ready = 1'b1;
      cyc("addi_t1d", E_T1S);
      cyc("addi_t2", E_T2);
      cyc("addi_t3", E_T3);
      cyc("addi_t4", e_t4i(OpAddi));
      cyc("addi_t5", E_T5);

      // jr
      set_op(OpJr);
      cyc("jr_t0", E_T0);
      cyc("jr_t1", E_T1F);
      cyc("jr_t2", E_T2);
      cyc("jr_t3", E_JR);

      // stop held in T0, then nop fetch
      set_op(OpNop);
      stop = 1'b1;
      for (int i = 0; i < 5; i++) cyc("stop_t0", E_IDLE);
      stop = 1'b0;
      cyc("nop_t0", E_T0);
      cyc("nop_t1", E_T1F);
      cyc("nop_t2", E_T2);
      cyc("nop_t3", E_IDLE);

      // undefined opcode runs as nop
      set_op(5'b11111);
      cyc("undef_t0", E_T0);
      cyc("undef_t1", E_T1F);
      cyc("undef_t2", E_T2);
      cyc("undef_t3", E_IDLE);

      // sub interrupted by reset in T4
      set_op(OpSub);
      cyc("sub_t0", E_T0);
      cyc("sub_t1", E_T1F);
      cyc("sub_t2", E_T2);
      cyc("sub_t3", E_T3);
      reset = 1'b1;
      cyc("sub_t4_rst", E_RST);
      reset = 1'b0;

      // halt, then hold ten cycles, then reset out
      set_op(OpHalt);
      cyc("halt_t0", E_T0);
      cyc("halt_t1", E_T1F);
      cyc("halt_t2", E_T2);
      cyc("halt_t3", E_IDLE);
      for (int i = 0; i < 10; i++) begin
         stop      = i[0];
         mem_ready = i[1];
         cyc("halted", E_HALT);
      end
      stop      = 1'b0;
      mem_ready = 1'b1;
      reset     = 1'b1;
      cyc("halt_rst", E_RST);
      reset = 1'b0;
      cyc("post_rst_t0", E_T0);
      cyc("post_rst_t1", E_T1F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
